// File: rtl/audio_pkg.sv
// audio_pkg: shared recorder state encoding and default widths.
package audio_pkg;
  localparam int AUDIO_ADDR_W = 20;
  localparam int AUDIO_SAMPLE_W = 10;
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} rec_state_t;
endpackage

// File: rtl/rec_addr_counter.sv
// rec_addr_counter: write-address counter with latched limit; holds at the limit instead of wrapping.
module rec_addr_counter
  import audio_pkg::*;
#(
  parameter int ADDR_W = AUDIO_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_max,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_max;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_max   <= '0;
    end else if (i_clr) begin
      r_count <= '0;
      r_max   <= i_max;
    end else if (i_inc && !o_last) begin
      r_count <= r_count + 1'b1;
    end
  end
  assign o_count = r_count;
  assign o_last  = r_count == r_max;
endmodule

// File: rtl/audio_recorder.sv
// audio_recorder: captures codec samples into memory until the latched limit or record drops.
// Optional REC_PEAK_EN adds a peak output tracking the largest sample of the current take.
module audio_recorder
  import audio_pkg::*;
#(
  parameter int ADDR_W   = AUDIO_ADDR_W,
  parameter int SAMPLE_W = AUDIO_SAMPLE_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                record,
  input  logic                audio_in_available,
  input  logic [SAMPLE_W-1:0] audio_in,
  input  logic [ADDR_W-1:0]   address_max,
`ifdef REC_PEAK_EN
  output logic [SAMPLE_W-1:0] peak,
`endif
  output logic                read_audio_in,
  output logic                clear_buffer,
  output logic                mem_wren,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [SAMPLE_W-1:0] mem_data,
  output logic                recording,
  output logic                full,
  output logic [ADDR_W:0]     length
);
  rec_state_t          r_state, w_next;
  logic                w_accept, w_last;
  logic [ADDR_W-1:0]   w_count;
  logic                r_wren;
  logic [ADDR_W-1:0]   r_addr;
  logic [SAMPLE_W-1:0] r_data;
  logic [ADDR_W:0]     r_len;
  assign w_accept = r_state == CAPTURE && record && audio_in_available;
  rec_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_clr  (r_state == ARM),
    .i_inc  (w_accept),
    .i_max  (address_max),
    .o_count(w_count),
    .o_last (w_last)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next        = r_state;
    read_audio_in = w_accept;
    clear_buffer  = r_state == IDLE || r_state == ARM;
    recording     = r_state == CAPTURE;
    full          = r_state == DONE;
    case (r_state)
      IDLE:    w_next = record ? ARM : IDLE;
      ARM:     w_next = CAPTURE;
      CAPTURE: w_next = !record ? IDLE : (w_accept && w_last) ? DONE : CAPTURE;
      DONE:    w_next = record ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wren <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_len  <= '0;
    end else begin
      r_wren <= w_accept;
      if (r_state == ARM) r_len <= '0;
      if (w_accept) begin
        r_addr <= w_count;
        r_data <= audio_in;
        r_len  <= r_len + 1'b1;
      end
    end
  end
`ifdef REC_PEAK_EN
  logic [SAMPLE_W-1:0] r_peak;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_peak <= '0;
    else if (r_state == ARM) r_peak <= '0;
    else if (w_accept && audio_in > r_peak) r_peak <= audio_in;
  end
  assign peak = r_peak;
`endif
  assign mem_wren    = r_wren;
  assign mem_address = r_addr;
  assign mem_data    = r_data;
  assign length      = r_len;
endmodule

// File: tb/tb_audio_recorder.sv
// tb_audio_recorder: directed scenario tasks with hand-computed expectations for audio_recorder.
module tb_audio_recorder;
  localparam int AW = 20;
  localparam int SW = 10;
  logic          clock = 1'b0;
  logic          reset, record, audio_in_available;
  logic [SW-1:0] audio_in;
  logic [AW-1:0] address_max;
  logic          read_audio_in, clear_buffer, mem_wren, recording, full;
  logic [AW-1:0] mem_address;
  logic [SW-1:0] mem_data;
  logic [AW:0]   length;
`ifdef REC_PEAK_EN
  logic [SW-1:0] peak;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  audio_recorder #(.ADDR_W(AW), .SAMPLE_W(SW)) dut (
    .clock(clock), .reset(reset), .record(record), .audio_in_available(audio_in_available),
    .audio_in(audio_in), .address_max(address_max),
`ifdef REC_PEAK_EN
    .peak(peak),
`endif
    .read_audio_in(read_audio_in), .clear_buffer(clear_buffer), .mem_wren(mem_wren),
    .mem_address(mem_address), .mem_data(mem_data), .recording(recording), .full(full), .length(length)
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1; record = 1'b0; audio_in_available = 1'b0; audio_in = '0; address_max = '0;
    tick(); tick();
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", mem_wren); end
    checks++; if ({recording, full} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {recording, full}); end
    checks++; if (mem_address !== '0 || mem_data !== '0 || length !== '0) begin errors++; $display("FAIL reset_regs got %h/%h/%h want 0", mem_address, mem_data, length); end
    checks++; if ({clear_buffer, read_audio_in} !== 2'b10) begin errors++; $display("FAIL reset_clr got %b want 10", {clear_buffer, read_audio_in}); end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_full_take();
    record = 1'b1; address_max = 3; audio_in_available = 1'b1; audio_in = 5;
    tick();
    checks++; if ({clear_buffer, recording} !== 2'b10) begin errors++; $display("FAIL arm_state got %b want 10", {clear_buffer, recording}); end
    tick();
    for (int i = 0; i < 4; i++) begin
      audio_in = SW'(5 + i); #1;
      checks++; if ({read_audio_in, recording} !== 2'b11) begin errors++; $display("FAIL take_pop%0d got %b want 11", i, {read_audio_in, recording}); end
      tick();
      checks++; if (mem_wren !== 1'b1 || mem_address !== AW'(i) || mem_data !== SW'(5 + i)) begin errors++; $display("FAIL take_wr%0d got %b/%0d/%0d want 1/%0d/%0d", i, mem_wren, mem_address, mem_data, i, 5 + i); end
    end
    audio_in = 9; #1;
    checks++; if ({full, read_audio_in} !== 2'b10) begin errors++; $display("FAIL take_done got %b want 10", {full, read_audio_in}); end
    checks++; if (length !== 4) begin errors++; $display("FAIL take_len got %0d want 4", length); end
    tick();
    checks++; if ({mem_wren, full, read_audio_in} !== 3'b010) begin errors++; $display("FAIL take_hold got %b want 010", {mem_wren, full, read_audio_in}); end
    record = 1'b0;
    tick();
    checks++; if ({full, clear_buffer} !== 2'b01 || length !== 4) begin errors++; $display("FAIL take_idle got %b len %0d want 01 len 4", {full, clear_buffer}, length); end
  endtask
  task automatic test_toggle();
    logic [4:0] pat;
    logic prev;
    int pops, wrs;
    pat = 5'b00101; prev = 1'b0; pops = 0; wrs = 0;
    record = 1'b1; address_max = 10; audio_in_available = 1'b0;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      audio_in_available = pat[k]; audio_in = SW'(20 + k); #1;
      checks++; if (read_audio_in !== pat[k] || mem_wren !== prev) begin errors++; $display("FAIL toggle_c%0d got pop %b wr %b want %b %b", k, read_audio_in, mem_wren, pat[k], prev); end
      if (mem_wren) begin
        checks++; if (mem_address !== AW'(wrs)) begin errors++; $display("FAIL toggle_addr got %0d want %0d", mem_address, wrs); end
        wrs++;
      end
      if (read_audio_in) pops++;
      prev = pat[k];
      tick();
    end
    checks++; if (pops !== 2 || wrs !== 2 || length !== 2) begin errors++; $display("FAIL toggle_cnt got %0d/%0d/%0d want 2/2/2", pops, wrs, length); end
    record = 1'b0;
    tick();
  endtask
  task automatic test_abort();
    record = 1'b1; address_max = 10; audio_in_available = 1'b1;
    tick(); tick();
    audio_in = 1; tick();
    audio_in = 2; tick();
    record = 1'b0; #1;
    checks++; if (read_audio_in !== 1'b0) begin errors++; $display("FAIL abort_pop got %b want 0", read_audio_in); end
    checks++; if (mem_wren !== 1'b1 || mem_address !== 1 || mem_data !== 2) begin errors++; $display("FAIL abort_last got %b/%0d/%0d want 1/1/2", mem_wren, mem_address, mem_data); end
    tick();
    checks++; if ({recording, clear_buffer, mem_wren} !== 3'b010 || length !== 2) begin errors++; $display("FAIL abort_idle got %b len %0d want 010 len 2", {recording, clear_buffer, mem_wren}, length); end
    tick();
    checks++; if ({mem_wren, read_audio_in} !== 2'b00) begin errors++; $display("FAIL abort_quiet got %b want 00", {mem_wren, read_audio_in}); end
  endtask
  task automatic test_single();
    record = 1'b1; address_max = 0; audio_in_available = 1'b1; audio_in = 10'h3FF;
    tick(); tick();
    checks++; if (read_audio_in !== 1'b1) begin errors++; $display("FAIL single_pop got %b want 1", read_audio_in); end
    tick();
    checks++; if ({full, mem_wren} !== 2'b11 || mem_address !== 0 || mem_data !== 10'h3FF || length !== 1) begin errors++; $display("FAIL single_wr got %b/%0d/%h len %0d want 11/0/3ff len 1", {full, mem_wren}, mem_address, mem_data, length); end
    tick();
    checks++; if ({full, mem_wren, read_audio_in} !== 3'b100) begin errors++; $display("FAIL single_hold got %b want 100", {full, mem_wren, read_audio_in}); end
    record = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid();
    record = 1'b1; address_max = 10; audio_in_available = 1'b1; audio_in = 7;
    tick(); tick(); tick();
    checks++; if (mem_wren !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b want 1", mem_wren); end
    reset = 1'b1; #1;
    checks++; if ({mem_wren, recording, full, read_audio_in, clear_buffer} !== 5'b00001) begin errors++; $display("FAIL rmid_flags got %b want 00001", {mem_wren, recording, full, read_audio_in, clear_buffer}); end
    checks++; if (mem_address !== '0 || mem_data !== '0 || length !== '0) begin errors++; $display("FAIL rmid_regs got %h/%h/%h want 0", mem_address, mem_data, length); end
    record = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++; if ({clear_buffer, recording, mem_wren} !== 3'b100) begin errors++; $display("FAIL rmid_idle got %b want 100", {clear_buffer, recording, mem_wren}); end
  endtask
`ifdef REC_PEAK_EN
  task automatic test_peak();
    record = 1'b1; address_max = 10; audio_in_available = 1'b1;
    tick(); tick();
    audio_in = 100; tick();
    audio_in = 900; tick();
    audio_in = 300; tick();
    checks++; if (peak !== 900) begin errors++; $display("FAIL peak_max got %0d want 900", peak); end
    record = 1'b0; audio_in_available = 1'b0;
    tick();
    record = 1'b1;
    tick(); tick();
    checks++; if (peak !== 0) begin errors++; $display("FAIL peak_clear got %0d want 0", peak); end
    record = 1'b0;
    tick();
  endtask
`endif
  initial begin
    test_reset();
    test_full_take();
    test_toggle();
    test_abort();
    test_single();
    test_reset_mid();
`ifdef REC_PEAK_EN
    test_peak();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
